// File: rtl/sha_stream_padder.sv
// rtl/sha_stream_padder.sv - SHA-256 message padder: byte stream in, padded 512-bit blocks out
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-low reset; discards any partial message
//   in_data    message byte (big-endian packing, byte 0 lands at [511:504])
//   in_valid   in_data valid
//   in_last    marks the final byte of a message (only meaningful with in_valid)
//   in_ready   padder accepts a byte this cycle
//   blk_data   512-bit block, byte i at [511-8i -: 8]
//   blk_valid  blk_data / blk_first / blk_last valid
//   blk_ready  downstream accepts the block
//   blk_first  block is the first of its message (downstream reloads initial H)
//   blk_last   block is the final one of its message (digest is complete after it)
module sha_stream_padder #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2,
        PAD2 = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [511:0]     blk_q, blk_d;
    logic [6:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             extra_q, extra_d;
    logic             need80_q, need80_d;
    logic             last_q, last_d;
    logic [63:0]      len_bits;

    // Message length in bits; counts every byte of the message, not just this block.
    assign len_bits = 64'(cnt_q) << 3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FILL;
            blk_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            extra_q  <= 1'b0;
            need80_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            extra_q  <= extra_d;
            need80_q <= need80_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        extra_d  = extra_q;
        need80_d = need80_q;
        last_d   = last_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int i = 0; i < 64; i++) begin
                        if (idx_q == 7'(i)) begin
                            blk_d[511-8*i -: 8] = in_data;
                        end
                    end
                    idx_d = idx_q + 7'd1;
                    cnt_d = cnt_q + 1'b1;
                    if (in_last) begin
                        state_d = PAD;
                    end else if (idx_q == 7'd63) begin
                        last_d  = 1'b0;
                        state_d = EMIT;
                    end
                end
            end

            PAD: begin
                // 0x80 terminator right after the data, zeros behind it. With a
                // full block (idx 64) nothing matches and the block is untouched.
                for (int i = 0; i < 64; i++) begin
                    if (idx_q == 7'(i)) begin
                        blk_d[511-8*i -: 8] = 8'h80;
                    end else if (idx_q < 7'(i)) begin
                        blk_d[511-8*i -: 8] = 8'h00;
                    end
                end
                if (idx_q <= 7'd55) begin
                    blk_d[63:0] = len_bits;
                    last_d      = 1'b1;
                end else begin
                    // Length does not fit: it goes in a trailing block, which
                    // also carries the terminator if this block had no room.
                    last_d   = 1'b0;
                    extra_d  = 1'b1;
                    need80_d = (idx_q == 7'd64);
                end
                state_d = EMIT;
            end

            EMIT: begin
                if (blk_ready) begin
                    first_d = 1'b0;
                    if (last_q) begin
                        cnt_d   = '0;
                        first_d = 1'b1;
                        idx_d   = '0;
                        blk_d   = '0;
                        state_d = FILL;
                    end else if (extra_q) begin
                        state_d = PAD2;
                    end else begin
                        idx_d   = '0;
                        blk_d   = '0;
                        state_d = FILL;
                    end
                end
            end

            PAD2: begin
                blk_d = '0;
                if (need80_q) begin
                    blk_d[511:504] = 8'h80;
                end
                blk_d[63:0] = len_bits;
                last_d      = 1'b1;
                extra_d     = 1'b0;
                need80_d    = 1'b0;
                state_d     = EMIT;
            end

            default: state_d = FILL;
        endcase
    end

    // in_ready is gated by reset so it drops the moment reset asserts.
    assign in_ready  = (state_q == FILL) && reset;
    assign blk_valid = (state_q == EMIT);
    assign blk_first = blk_valid && first_q;
    assign blk_last  = blk_valid && last_q;
    assign blk_data  = blk_q;

endmodule

// File: tb/tb_sha_stream_padder.sv
// tb/tb_sha_stream_padder.sv - self-checking bench for sha_stream_padder
module tb_sha_stream_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } exp_t;

    logic [7:0] msg[$];
    logic       lastq[$];
    exp_t       exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    sha_stream_padder #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    // Reference: pad the whole message as a byte array, then cut into 64-byte blocks.
    task automatic add_message(input int len, input int mode, input logic [7:0] val);
        logic [7:0] m[$];
        logic [7:0] p[$];
        logic [7:0] b;
        logic [63:0] bits;
        exp_t e;
        int nblk;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       b = 8'($urandom);
                1:       b = val;
                default: b = 8'(i);
            endcase
            m.push_back(b);
            msg.push_back(b);
            lastq.push_back(i == len - 1);
        end
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int bk = 0; bk < nblk; bk++) begin
            e.d = '0;
            for (int j = 0; j < 64; j++) e.d[511-8*j -: 8] = p[64*bk+j];
            e.f = (bk == 0);
            e.l = (bk == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_stream(input int start, input int gap, input int rdy);
        int bi;
        int cyc;
        exp_t e;
        bi  = start;
        cyc = 0;
        while ((bi < msg.size() || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (bi < msg.size() && $urandom_range(99) >= gap) begin
                in_valid = 1'b1;
                in_data  = msg[bi];
                in_last  = lastq[bi];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            blk_ready = ($urandom_range(99) < rdy);
            if (blk_valid) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ready_in_emit: got %b, expected 0", in_ready);
                end
            end
            if (in_valid && in_ready) bi++;
            if (blk_valid && blk_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_block: got block %h, expected none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({blk_data, blk_first, blk_last} !== {e.d, e.f, e.l}) begin
                        miscompares++;
                        $display("FAIL block: got first=%b last=%b data=%h, expected first=%b last=%b data=%h",
                                 blk_first, blk_last, blk_data, e.f, e.l, e.d);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        vectors++;
        if (bi != msg.size() || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_timeout: got %0d bytes sent / %0d blocks pending, expected %0d / 0",
                     bi, exp_q.size(), msg.size());
        end
        msg.delete();
        lastq.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy/vld/first/last=%b, expected 0000",
                     {in_ready, blk_valid, blk_first, blk_last});
        end
        vectors++;
        if (blk_data !== 512'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, expected 0", blk_data);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_abc();
        logic [7:0]   abc[3];
        logic [511:0] want;
        abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63;
        want = '0;
        want[511:480] = 32'h61626380;
        want[63:0]    = 64'h18;
        blk_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = abc[i];
            in_last  = (i == 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (blk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_latency_early: got blk_valid=%b, expected 0", blk_valid);
        end
        @(negedge clk);
        vectors++;
        if ({blk_valid, blk_first, blk_last} !== 3'b111) begin
            miscompares++;
            $display("FAIL abc_flags: got vld/first/last=%b, expected 111", {blk_valid, blk_first, blk_last});
        end
        vectors++;
        if (blk_data !== want) begin
            miscompares++;
            $display("FAIL abc_data: got %h, expected %h", blk_data, want);
        end
        @(negedge clk);
        blk_ready = 1'b0;
        vectors++;
        if ({blk_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL abc_return_fill: got vld/rdy=%b, expected 01", {blk_valid, in_ready});
        end
    endtask

    task automatic test_boundaries();
        add_message(55, 1, 8'h00);
        run_stream(0, 20, 70);
        add_message(56, 1, 8'hFF);
        run_stream(0, 20, 70);
        add_message(64, 2, 8'h00);
        run_stream(0, 20, 70);
        add_message(130, 2, 8'h00);
        run_stream(0, 20, 70);
    endtask

    task automatic test_backpressure();
        logic [511:0] held;
        add_message(130, 0, 8'h00);
        blk_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_data = msg[64];
        vectors++;
        if ({blk_valid, in_ready, blk_first, blk_last} !== 4'b1010) begin
            miscompares++;
            $display("FAIL full_block_latency: got vld/rdy/first/last=%b, expected 1010",
                     {blk_valid, in_ready, blk_first, blk_last});
        end
        held = blk_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({blk_data, blk_valid, in_ready, blk_first, blk_last} !== {held, 4'b1010}) begin
                miscompares++;
                $display("FAIL backpressure_hold: got vld/rdy/first/last=%b data=%h, expected 1010 data=%h",
                         {blk_valid, in_ready, blk_first, blk_last}, blk_data, held);
            end
        end
        run_stream(64, 0, 100);
    endtask

    task automatic test_back_to_back();
        add_message(10, 0, 8'h00);
        add_message(64, 0, 8'h00);
        add_message(5, 0, 8'h00);
        run_stream(0, 0, 100);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) add_message($urandom_range(200, 1), 0, 8'h00);
            run_stream(0, 30, 60);
        end
    endtask

    task automatic test_reset_mid();
        blk_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom) | 8'h01;
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        vectors++;
        if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b0000 || blk_data !== 512'd0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got rdy/vld/first/last=%b data=%h, expected 0000 data=0",
                     {in_ready, blk_valid, blk_first, blk_last}, blk_data);
        end
        @(negedge clk);
        reset = 1'b1;
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
